// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, single-outstanding memory port and
// a first-word-fall-through prefetch FIFO, with redirect flush.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_valid,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     if_valid,
  output logic [31:0]              if_instr,
  output logic [XLEN-1:0]          if_pc,
  output logic [XLEN-1:0]          if_pcp4,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     fetch_misalign
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            discard_q, discard_d;
  logic            misalign_q, misalign_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic            pop;
  logic            push;
  logic            rsp;
  logic            issue;
  logic [CW:0]     count_after;

  always_comb begin
    rsp  = imem_valid && outstanding_q;
    pop  = (count_q != '0) && id_ready;
    push = rsp && !discard_q && !redirect;
    // Occupancy as it will be after this cycle's push/pop, so the FIFO always
    // has a free slot reserved for the response of any issued request.
    count_after = {1'b0, count_q} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    issue = !reset && !redirect && (!outstanding_q || imem_valid) &&
            (count_after < DEPTH_W);
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    misalign_d    = misalign_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      if (rsp) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end else if (outstanding_q) begin
        discard_d = 1'b1;
      end
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      if (rsp) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end
      if (issue) begin
        outstanding_d = 1'b1;
        fetch_pc_d    = fetch_pc_q + XLEN'(4);
        req_pc_d      = fetch_pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_after[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= RESET_PC;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      misalign_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      misalign_q    <= misalign_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign imem_req       = issue;
  assign imem_addr      = fetch_pc_q;
  assign if_valid       = (count_q != '0);
  assign if_instr       = instr_mem[rd_ptr_q];
  assign if_pc          = pc_mem[rd_ptr_q];
  assign if_pcp4        = pc_mem[rd_ptr_q] + XLEN'(4);
  assign occupancy      = count_q;
  assign fetch_misalign = misalign_q;

endmodule
